// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and the external memory.
// Names keep the arbiter's point of view: *_i enter the arbiter, *_o leave it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: if_req_i/dm_req_i are levels held until the matching one-cycle
  // *_ack_o pulse (rdata valid in that cycle); mem_req_o holds every mem_* field
  // stable until the edge that samples mem_ack_i = 1 (or the timeout abort).
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_flush_i;
  logic                  if_ack_o;
  logic [DATA_W-1:0]     if_rdata_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [ADDR_W-1:0]     dm_addr_i;
  logic [DATA_W-1:0]     dm_wdata_i;
  logic [DATA_W/8-1:0]   dm_sel_i;
  logic                  dm_ack_o;
  logic [DATA_W-1:0]     dm_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_sel_o;
  logic [DATA_W-1:0]     mem_rdata_i;
  logic                  mem_ack_i;

  logic                  err_o;
  logic                  busy_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_ack_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_sel_i,
    output dm_ack_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    input  mem_rdata_i, mem_ack_i,
    output err_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_ack_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_sel_i,
    input  dm_ack_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    output mem_rdata_i, mem_ack_i,
    input  err_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access.
// DM has fixed priority; every output is registered; optional bus timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam int SEL_W = DATA_W / 8;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                owner_dm;
  logic                drop_now;
  logic                timeout_hit;

  assign owner_dm    = (state_q == S_DM_BUSY);
  // A flush landing on the completing edge still suppresses the fetch ack.
  assign drop_now    = drop_q | bus.if_flush_i;
  assign timeout_hit = TO_EN && (cnt_q == TO_LIM);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = 1'b0;
    drop_d      = drop_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (bus.dm_req_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          mem_sel_d   = bus.dm_sel_i;
          cnt_d       = '0;
          state_d     = S_DM_BUSY;
        end else if (bus.if_req_i && !bus.if_flush_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
          mem_sel_d   = '1;
          cnt_d       = '0;
          state_d     = S_IF_BUSY;
        end
      end

      S_IF_BUSY, S_DM_BUSY: begin
        if (!owner_dm && bus.if_flush_i) begin
          drop_d = 1'b1;
        end
        // A real completion beats a timeout that expires on the same edge.
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (owner_dm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata_i;
          end else if (!drop_now) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata_i;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (owner_dm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
            err_d      = 1'b1;
          end else if (!drop_now) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
            err_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_sel_o   = mem_sel_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of priority, latency and timeout.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [33:0] exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.if_flush_i  = 1'b0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = '0;
    bus.dm_wdata_i  = '0;
    bus.dm_sel_i    = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
  endtask

  task automatic test_reset();
    logic [137:0] all_out;
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    all_out = {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o,
               bus.if_ack_o, bus.dm_ack_o, bus.if_rdata_o, bus.dm_rdata_o, bus.err_o, bus.busy_o};
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_o, bus.mem_req_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: got %b want 00", {bus.busy_o, bus.mem_req_o});
    end
  endtask

  task automatic test_single_if();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.busy_o} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b1}) begin
      n_err++;
      $display("FAIL single_if_req: got req=%b we=%b addr=%h sel=%h busy=%b want 1 0 100 f 1",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.busy_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0050_0093;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack_o, bus.dm_ack_o, bus.if_rdata_o, bus.mem_req_o} !== {1'b1, 1'b0, 32'h0050_0093, 1'b0}) begin
      n_err++;
      $display("FAIL single_if_ack: got ack=%b dmack=%b rdata=%h req=%b want 1 0 00500093 0",
               bus.if_ack_o, bus.dm_ack_o, bus.if_rdata_o, bus.mem_req_o);
    end
    bus.if_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_o, bus.if_ack_o} !== 2'b00) begin
      n_err++;
      $display("FAIL single_if_idle: got busy/ack %b want 00", {bus.busy_o, bus.if_ack_o});
    end
  endtask

  task automatic test_collision();
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h2000;
    bus.dm_wdata_i = 32'hDEAD_BEEF;
    bus.dm_sel_i   = 4'h3;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h104;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o} !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3}) begin
      n_err++;
      $display("FAIL collision_dm_req: got req=%b we=%b addr=%h wdata=%h sel=%h want 1 1 2000 deadbeef 3",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    n_cmp++;
    if ({bus.dm_ack_o, bus.if_ack_o, bus.dm_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL collision_dm_ack: got dmack=%b ifack=%b rdata=%h want 1 0 0",
               bus.dm_ack_o, bus.if_ack_o, bus.dm_rdata_o);
    end
    bus.dm_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_o, bus.mem_req_o} !== 2'b00) begin
      n_err++;
      $display("FAIL collision_gap: got busy/req %b want 00", {bus.busy_o, bus.mem_req_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o} !== {1'b1, 1'b0, 32'h104, 4'hF}) begin
      n_err++;
      $display("FAIL collision_if_req: got req=%b we=%b addr=%h sel=%h want 1 0 104 f",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0000_0013;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack_o, bus.if_rdata_o} !== {1'b1, 32'h13}) begin
      n_err++;
      $display("FAIL collision_if_ack: got ack=%b rdata=%h want 1 13", bus.if_ack_o, bus.if_rdata_o);
    end
    bus.if_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h200;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h200}) begin
        n_err++;
        $display("FAIL flush_hold c%0d: got req=%b addr=%h want 1 200", c, bus.mem_req_o, bus.mem_addr_o);
      end
      bus.if_flush_i = (c == 2);
      if (c == 2) bus.if_req_i = 1'b0;
      bus.mem_ack_i   = (c == 5);
      bus.mem_rdata_i = 32'hBADB_AD00;
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack_o, bus.if_rdata_o, bus.mem_req_o, bus.busy_o} !== {1'b0, 32'h13, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_drop: got ack=%b rdata=%h req=%b busy=%b want 0 13 0 1",
               bus.if_ack_o, bus.if_rdata_o, bus.mem_req_o, bus.busy_o);
    end
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    // Flush in IDLE must block this cycle's grant.
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h300;
    bus.if_flush_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_idle_block: got req/busy %b want 00", {bus.mem_req_o, bus.busy_o});
    end
    bus.if_flush_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h300}) begin
      n_err++;
      $display("FAIL flush_next_req: got req=%b addr=%h want 1 300", bus.mem_req_o, bus.mem_addr_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h00A0_0113;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack_o, bus.if_rdata_o} !== {1'b1, 32'h00A0_0113}) begin
      n_err++;
      $display("FAIL flush_next_ack: got ack=%b rdata=%h want 1 00a00113", bus.if_ack_o, bus.if_rdata_o);
    end
    bus.if_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = 32'h4000;
    bus.dm_sel_i  = 4'hF;
    @(negedge clk);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({bus.dm_ack_o, bus.dm_rdata_o, bus.err_o} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_pre_read: got ack=%b rdata=%h err=%b want 1 12345678 0",
               bus.dm_ack_o, bus.dm_rdata_o, bus.err_o);
    end
    bus.dm_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h4004;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_req_o, bus.dm_ack_o, bus.err_o} !== 3'b100) begin
        n_err++;
        $display("FAIL timeout_wait c%0d: got req/ack/err %b want 100", c, {bus.mem_req_o, bus.dm_ack_o, bus.err_o});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.dm_ack_o, bus.err_o, bus.dm_rdata_o} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL timeout_abort: got req=%b ack=%b err=%b rdata=%h want 0 1 1 0",
               bus.mem_req_o, bus.dm_ack_o, bus.err_o, bus.dm_rdata_o);
    end
    bus.dm_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.dm_ack_o, bus.err_o, bus.busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL timeout_after: got ack/err/busy %b want 000", {bus.dm_ack_o, bus.err_o, bus.busy_o});
    end
  endtask

  task automatic test_reset_mid_op();
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h5000;
    bus.dm_wdata_i = 32'h1111_2222;
    bus.dm_sel_i   = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, bus.busy_o} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_mid_busy: got req/busy %b want 11", {bus.mem_req_o, bus.busy_o});
    end
    #2;
    rst_n        = 1'b0;
    bus.dm_req_i = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req_o, bus.busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_async: got req/busy %b want 00", {bus.mem_req_o, bus.busy_o});
    end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mem_ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.dm_ack_o, bus.if_ack_o, bus.mem_req_o, bus.busy_o, bus.err_o} !== 5'b0) begin
        n_err++;
        $display("FAIL rst_late_ack c%0d: got %b want 00000", c,
                 {bus.dm_ack_o, bus.if_ack_o, bus.mem_req_o, bus.busy_o, bus.err_o});
      end
    end
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_held_requests();
    int   n_ack = 0;
    int   n_grant = 0;
    logic prev_req = 1'b0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h500;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.mem_req_o && !prev_req) n_grant++;
      prev_req = bus.mem_req_o;
      if (bus.if_ack_o) begin
        n_cmp++;
        if (c != 2 + 3 * n_ack || bus.if_rdata_o !== 32'(c - 1)) begin
          n_err++;
          $display("FAIL held_ack: got cycle %0d rdata %h want cycle %0d rdata %h",
                   c, bus.if_rdata_o, 2 + 3 * n_ack, 32'(c - 1));
        end
        n_ack++;
        if (n_ack == 3) bus.if_req_i = 1'b0;
      end
      bus.mem_ack_i   = bus.mem_req_o;
      bus.mem_rdata_i = 32'(c);
    end
    bus.mem_ack_i = 1'b0;
    n_cmp++;
    if (n_ack != 3 || n_grant != 3) begin
      n_err++;
      $display("FAIL held_count: got acks %0d grants %0d want 3 3", n_ack, n_grant);
    end
  endtask

  task automatic test_random(input int n_txn);
    for (int t = 0; t < n_txn; t++) begin
      int          mode, ntx, cur, req_cycles, pick;
      int          dly[2];
      int          exp_len[2];
      logic        is_dm[2];
      logic [68:0] mexp[2];
      logic [31:0] mdat[2];
      logic [31:0] rd;
      logic        tmo;
      logic [33:0] got;
      mode = $urandom_range(0, 3);
      bus.dm_we_i    = 1'($urandom_range(0, 1));
      bus.dm_addr_i  = $urandom;
      bus.dm_wdata_i = $urandom;
      bus.dm_sel_i   = 4'($urandom_range(1, 15));
      bus.if_addr_i  = $urandom & 32'hFFFF_FFFC;
      ntx      = (mode >= 2) ? 2 : 1;
      is_dm[0] = (mode == 0 || mode == 2);
      is_dm[1] = (mode == 3);
      for (int k = 0; k < ntx; k++) begin
        pick    = $urandom_range(0, 9);
        dly[k]  = (pick <= 5) ? pick % 4 : (pick <= 7) ? TO - 1 : 1000;
        mdat[k] = $urandom;
        mexp[k] = is_dm[k] ? {bus.dm_we_i, bus.dm_addr_i, bus.dm_wdata_i, bus.dm_sel_i}
                           : {1'b0, bus.if_addr_i, 32'h0, 4'hF};
        tmo        = (dly[k] >= TO);
        exp_len[k] = tmo ? TO : dly[k] + 1;
        rd         = (tmo || (is_dm[k] && bus.dm_we_i)) ? 32'h0 : mdat[k];
        exp_q.push_back({is_dm[k], tmo, rd});
      end
      @(negedge clk);
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_idle t%0d: got busy %b want 0", t, bus.busy_o);
      end
      bus.dm_req_i = (mode == 0 || mode == 2);
      bus.if_req_i = (mode != 0);
      cur = 0;
      req_cycles = 0;
      for (int c = 0; c < 200 && cur < ntx; c++) begin
        @(negedge clk);
        if (bus.dm_ack_o || bus.if_ack_o) begin
          got = {bus.dm_ack_o, bus.err_o, bus.dm_ack_o ? bus.dm_rdata_o : bus.if_rdata_o};
          n_cmp++;
          if ((bus.dm_ack_o && bus.if_ack_o) || got !== exp_q[0] || req_cycles != exp_len[cur]) begin
            n_err++;
            $display("FAIL rnd_resp t%0d: got dm/err/rdata %h len %0d both=%b want %h len %0d",
                     t, got, req_cycles, bus.dm_ack_o && bus.if_ack_o, exp_q[0], exp_len[cur]);
          end
          void'(exp_q.pop_front());
          if (is_dm[cur]) bus.dm_req_i = 1'b0;
          else bus.if_req_i = 1'b0;
          cur++;
          req_cycles = 0;
        end
        if (bus.mem_req_o && cur < ntx) begin
          req_cycles++;
          n_cmp++;
          if ({bus.mem_we_o, bus.mem_addr_o, is_dm[cur] ? bus.mem_wdata_o : 32'h0, bus.mem_sel_o} !== mexp[cur]) begin
            n_err++;
            $display("FAIL rnd_bus t%0d: got %h want %h", t,
                     {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o}, mexp[cur]);
          end
          bus.mem_ack_i   = (req_cycles == dly[cur] + 1);
          bus.mem_rdata_i = bus.mem_ack_i ? mdat[cur] : $urandom;
          if (mode == 3 && cur == 0) bus.dm_req_i = 1'b1;
        end else if (bus.mem_req_o) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_extra_grant t%0d: got req 1 want 0", t);
          bus.mem_ack_i = 1'b1;
        end else begin
          bus.mem_ack_i   = 1'($urandom_range(0, 1));
          bus.mem_rdata_i = $urandom;
        end
      end
      if (cur < ntx) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_hang t%0d: got %0d responses want %0d", t, cur, ntx);
        exp_q.delete();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    bus.mem_ack_i = 1'b0;
    bus.dm_req_i  = 1'b0;
    bus.if_req_i  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_collision();
    test_flush();
    test_timeout();
    test_reset_mid_op();
    test_held_requests();
    test_random(60);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one external single-ported memory bus between instruction fetch (IF) and data access (DM, from the MEM stage) of the RISC-V pipeline.
- Each transaction is sequenced through a request/acknowledge FSM with registered outputs.
- DM has fixed priority over IF, since DM is the older instruction.
- Also supports IF flush (drop an in-flight fetch) and a bus timeout that reports an error.

Parameters:
- ADDR_W, 32, address width of requester and memory sides.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, max cycles mem_req_o stays high without mem_ack_i before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_i  in  1  IF read request, level, held until if_ack_o.
- if_addr_i  in  ADDR_W  IF fetch address.
- if_flush_i  in  1  cancel the outstanding or pending IF request (branch taken).
- if_ack_o  out  1  one-cycle pulse, if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched instruction.
- dm_req_i  in  1  DM request, level, held until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_sel_i  in  DATA_W/8  byte enables.
- dm_ack_o  out  1  one-cycle pulse, dm_rdata_o valid.
- dm_rdata_o  out  DATA_W  load data; 0 for writes.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_sel_o  out  DATA_W/8  byte enables (all ones for IF).
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion, sampled only while mem_req_o = 1.
- err_o  out  1  one-cycle pulse with the requester ack on timeout.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous, immediate, including mid-transaction.
  - State = IDLE.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o, if_ack_o, dm_ack_o, both rdata outputs, err_o, busy_o.
  - Internal drop flag and timeout counter cleared.
- All outputs are registered.
- FSM states: IDLE, IF_BUSY, DM_BUSY, RESP.
- IDLE:
  - dm_req_i = 1 → latch dm_we/addr/wdata/sel onto mem_* and set mem_req_o = 1; next state DM_BUSY.
  - Else if if_req_i = 1 and if_flush_i = 0 → mem_addr_o = if_addr_i, mem_we_o = 0, mem_sel_o = all ones, mem_req_o = 1; next state IF_BUSY.
  - Simultaneous requests: DM wins; IF waits.
- IF_BUSY / DM_BUSY:
  - mem_* held stable while mem_req_o = 1.
  - On the edge that samples mem_ack_i = 1: mem_req_o ← 0; capture mem_rdata_i (forced to 0 for a DM write); next state RESP.
  - In that same edge, assert the owner's ack (dm_ack_o, or if_ack_o unless the drop flag is set).
- RESP:
  - Lasts exactly one cycle, with the ack pulse high; all requests are ignored.
  - Next state IDLE. This gives the requester one edge to drop its req, so there is no double grant.
  - rdata outputs hold their value until the next capture.
- Latency: requester req seen in cycle 0 → mem_req_o high in cycle 1 → if mem_ack_i arrives in cycle 1, ack in cycle 2 → IDLE in cycle 3. Back-to-back grant period is 3 cycles minimum.
- Flush:
  - if_flush_i in IF_BUSY sets the drop flag. The bus cycle still completes (the memory cannot be aborted).
  - On completion if_ack_o stays 0 and rdata is not updated; the flag clears on leaving RESP.
  - Flush in IDLE blocks an IF grant that cycle.
  - Flush in RESP has no effect; the IF stage discards that ack.
  - Flush in DM_BUSY has no effect.
- Timeout (TIMEOUT > 0):
  - A counter increments each cycle mem_req_o = 1 and mem_ack_i = 0, and clears on entry to BUSY.
  - When the counter reaches TIMEOUT: mem_req_o ← 0, owner ack ← 1 (subject to the drop flag), rdata ← 0, err_o ← 1; next state RESP.
  - mem_ack_i and timeout on the same edge → the ack wins; no err.
- mem_ack_i while mem_req_o = 0 is ignored.
- DM requests arriving during an IF transaction wait; no preemption.

Test Plan:
- Single IF: if_req_i = 1, if_addr_i = 0x100, mem_ack_i in the first mem_req_o cycle with rdata 0x00500093 → mem_addr_o = 0x100, mem_sel_o = 0xF; if_ack_o high cycle 2 with if_rdata_o = 0x00500093; busy_o low cycle 3.
- Collision: if_req_i and dm_req_i (write, addr 0x2000, wdata 0xDEADBEEF, sel 0x3) rise together → DM served first with mem_we_o = 1, sel 0x3; dm_rdata_o = 0; IF granted right after the RESP cycle.
- Flush: IF grant with memory ack delayed 4 cycles, if_flush_i pulsed in BUSY cycle 2 → mem_req_o held until the ack; no if_ack_o; if_rdata_o unchanged; next IF request served normally.
- Timeout: TIMEOUT = 8, DM read, mem_ack_i never asserted → mem_req_o high for exactly 8 cycles; then dm_ack_o = err_o = 1 for one cycle with dm_rdata_o = 0.
- Reset mid-op: rst_n low during DM_BUSY → mem_req_o and busy_o drop asynchronously; after release, a late mem_ack_i produces no ack.
- Held requests: if_req_i held continuously over 3 fetches → exactly one if_ack_o per grant, 3-cycle spacing, no duplicate grant.
